// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decrypt-round datapath blocks:
// FSM state encoding, state-buffer geometry, the inverse S-box table
// and the row/column helper used by InvShiftRows.
package aes_dec_pkg;

  // One-hot control states shared by the statemt-buffer stages.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READ  = 4'b0010,
    ST_WRITE = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  localparam int STATE_WORDS = 16;
  localparam int ROWS        = 4;
  localparam int COLS        = 4;

  // Last step index of each phase. READ has one extra step because the
  // RAM returns data one cycle after the address is presented.
  localparam logic [3:0] READ_LAST_K  = 4'd8;
  localparam logic [3:0] WRITE_LAST_K = 4'd7;

  // Inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX_FLAT = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox_lookup(input logic [7:0] x);
    return INV_SBOX_FLAT[8*(255 - int'(x)) +: 8];
  endfunction

  // Word index r + 4*c -> buffer index holding the byte that InvShiftRows
  // moves there: row r, column (c - r) mod 4 (2-bit wrap-around).
  function automatic logic [3:0] src_index(input logic [3:0] word);
    logic [1:0] row;
    logic [1:0] col;
    row = word[1:0];
    col = word[3:2] - row;
    return {col, row};
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational inverse S-box lookup, one byte in, one byte out.
module inv_sbox
  import aes_dec_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = inv_sbox_lookup(i_byte);

endmodule

// File: rtl/inv_shift_row_byte_sub.sv
// InvShiftRows + InvSubBytes applied in place on the dual-port statemt RAM.
// All 16 bytes are read into a local buffer (two per cycle), then the
// shifted, substituted bytes are written back two per cycle.
// Optional feature macro: LOGIC_LOCK_EN adds the working_key input that
// gates the read phase and masks the write data.
module inv_shift_row_byte_sub
  import aes_dec_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
`ifdef LOGIC_LOCK_EN
  input  logic [63:0]       working_key,
`endif
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] statemt_address0,
  output logic              statemt_ce0,
  output logic              statemt_we0,
  output logic [DATA_W-1:0] statemt_d0,
  input  logic [DATA_W-1:0] statemt_q0,
  output logic [ADDR_W-1:0] statemt_address1,
  output logic              statemt_ce1,
  output logic              statemt_we1,
  output logic [DATA_W-1:0] statemt_d1,
  input  logic [DATA_W-1:0] statemt_q1
);

  // Handshake: ap_start is sampled only in IDLE; ap_done and ap_ready pulse
  // together for one cycle in DONE; ap_idle is high in IDLE while ap_start=0.

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_k;
  logic [3:0] w_k_nxt;
  logic [7:0] r_buf [STATE_WORDS];

  logic [3:0] w_word0;
  logic [3:0] w_word1;
  logic [3:0] w_kp;
  logic [7:0] w_sbox_in0;
  logic [7:0] w_sbox_in1;
  logic [7:0] w_sbox_out0;
  logic [7:0] w_sbox_out1;
  logic [7:0] w_key_mask;
  logic       w_skip_read;
  logic       w_unused;

`ifdef LOGIC_LOCK_EN
  logic w_unused_key;
  assign w_skip_read  = working_key[12];
  assign w_key_mask   = working_key[20:13] ^ 8'h5A;
  assign w_unused_key = ^{working_key[63:21], working_key[11:0]};
`else
  assign w_skip_read = 1'b0;
  assign w_key_mask  = 8'h00;
`endif

  // Each step k touches the word pair {2k, 2k+1}.
  assign w_word0 = {r_k[2:0], 1'b0};
  assign w_word1 = {r_k[2:0], 1'b1};
  assign w_kp    = r_k - 4'd1;

  assign w_sbox_in0 = r_buf[src_index(w_word0)];
  assign w_sbox_in1 = r_buf[src_index(w_word1)];

  assign w_unused = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8], w_kp[3]};

  inv_sbox u_inv_sbox0 (
    .i_byte (w_sbox_in0),
    .o_byte (w_sbox_out0)
  );

  inv_sbox u_inv_sbox1 (
    .i_byte (w_sbox_in1),
    .o_byte (w_sbox_out1)
  );

  // State and step counter registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
      r_k     <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Next-state and step counter.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      ST_IDLE: begin
        if (ap_start) begin
          w_k_nxt     = 4'd0;
          w_state_nxt = w_skip_read ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (r_k == READ_LAST_K) begin
          w_k_nxt     = 4'd0;
          w_state_nxt = ST_WRITE;
        end else begin
          w_k_nxt = r_k + 4'd1;
        end
      end
      ST_WRITE: begin
        if (r_k == WRITE_LAST_K) begin
          w_k_nxt     = 4'd0;
          w_state_nxt = ST_DONE;
        end else begin
          w_k_nxt = r_k + 4'd1;
        end
      end
      ST_DONE: begin
        w_k_nxt     = 4'd0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_k_nxt     = 4'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // RAM port controls and handshake outputs decoded from the current state.
  always_comb begin
    ap_done          = 1'b0;
    ap_ready         = 1'b0;
    ap_idle          = 1'b0;
    statemt_ce0      = 1'b0;
    statemt_we0      = 1'b0;
    statemt_ce1      = 1'b0;
    statemt_we1      = 1'b0;
    statemt_address0 = '0;
    statemt_address1 = '0;
    statemt_d0       = '0;
    statemt_d1       = '0;
    case (r_state)
      ST_IDLE: begin
        ap_idle = !ap_start;
      end
      ST_READ: begin
        if (r_k != READ_LAST_K) begin
          statemt_ce0      = 1'b1;
          statemt_ce1      = 1'b1;
          statemt_address0 = {{(ADDR_W-4){1'b0}}, w_word0};
          statemt_address1 = {{(ADDR_W-4){1'b0}}, w_word1};
        end
      end
      ST_WRITE: begin
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_we0      = 1'b1;
        statemt_we1      = 1'b1;
        statemt_address0 = {{(ADDR_W-4){1'b0}}, w_word0};
        statemt_address1 = {{(ADDR_W-4){1'b0}}, w_word1};
        statemt_d0       = {{(DATA_W-8){1'b0}}, w_sbox_out0 ^ w_key_mask};
        statemt_d1       = {{(DATA_W-8){1'b0}}, w_sbox_out1 ^ w_key_mask};
      end
      ST_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
      end
      default: begin
        ap_idle = 1'b0;
      end
    endcase
  end

  // Capture read data one step after its address was issued.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < STATE_WORDS; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else if (r_state == ST_READ && r_k != 4'd0) begin
      r_buf[{w_kp[2:0], 1'b0}] <= statemt_q0[7:0];
      r_buf[{w_kp[2:0], 1'b1}] <= statemt_q1[7:0];
    end
  end

endmodule

// File: tb/tb_inv_shift_row_byte_sub.sv
// Bench for inv_shift_row_byte_sub: dual-port RAM model, reference inverse
// S-box derived from GF(2^8) inversion, write scoreboard, vector table.
// Build with LOGIC_LOCK_EN defined to also exercise the key-gated paths.
module tb_inv_shift_row_byte_sub;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int EW     = ADDR_W + DATA_W;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic              ap_start = 1'b0;
  logic              ap_done, ap_idle, ap_ready;
  logic [ADDR_W-1:0] statemt_address0, statemt_address1;
  logic              statemt_ce0, statemt_we0, statemt_ce1, statemt_we1;
  logic [DATA_W-1:0] statemt_d0, statemt_d1;
  logic [DATA_W-1:0] statemt_q0 = '0;
  logic [DATA_W-1:0] statemt_q1 = '0;
`ifdef LOGIC_LOCK_EN
  logic [63:0]       working_key = 64'h0123_4567_000B_4000;
`endif

  // Clock and reset are driven from here and the main initial block.
  always #5 ap_clk = ~ap_clk;

  inv_shift_row_byte_sub #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
`ifdef LOGIC_LOCK_EN
    .working_key      (working_key),
`endif
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .statemt_address0 (statemt_address0),
    .statemt_ce0      (statemt_ce0),
    .statemt_we0      (statemt_we0),
    .statemt_d0       (statemt_d0),
    .statemt_q0       (statemt_q0),
    .statemt_address1 (statemt_address1),
    .statemt_ce1      (statemt_ce1),
    .statemt_we1      (statemt_we1),
    .statemt_d1       (statemt_d1),
    .statemt_q1       (statemt_q1)
  );

  // RAM model: one-cycle read latency on both ports, bench image load.
  logic [31:0] mem    [32];
  logic [31:0] tb_img [32];
  logic        tb_load = 1'b0;

  always @(posedge ap_clk) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= tb_img[i];
    end else begin
      if (statemt_ce0) begin
        if (statemt_we0) mem[statemt_address0] <= statemt_d0;
        else             statemt_q0 <= mem[statemt_address0];
      end
      if (statemt_ce1) begin
        if (statemt_we1) mem[statemt_address1] <= statemt_d1;
        else             statemt_q1 <= mem[statemt_address1];
      end
    end
  end

  // Scoreboard state and counters.
  logic [EW-1:0] exp_q[$];
  logic [7:0]    inv_ref [256];
  logic [7:0]    key_mask = 8'h00;
  int            checks = 0;
  int            errors = 0;
  int            rd_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Compare every DUT write, in port-0 then port-1 order, against the queue.
  always @(negedge ap_clk) begin
    if (statemt_ce0 && !statemt_we0) rd_cnt++;
    if (statemt_ce1 && !statemt_we1) rd_cnt++;
    if (statemt_we0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write0 actual=%0h expected=none", {statemt_address0, statemt_d0});
      end else check("write_port0", {statemt_address0, statemt_d0}, exp_q.pop_front());
    end
    if (statemt_we1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write1 actual=%0h expected=none", {statemt_address1, statemt_d1});
      end else check("write_port1", {statemt_address1, statemt_d1}, exp_q.pop_front());
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Forward S-box from inversion + affine map, then invert it.
  task automatic build_inv_ref();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_ref[s] = 8'(x);
    end
  endtask

  task automatic load_image(input int mode, input logic [23:0] upper);
    logic [7:0] b;
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       b = 8'h63;
        1:       b = 8'(i);
        default: b = 8'($urandom_range(0, 255));
      endcase
      tb_img[i] = (i < 16) ? {upper, b} : {24'hDEAD00, 8'(i)};
    end
    @(negedge ap_clk); tb_load = 1'b1;
    @(posedge ap_clk); #1; tb_load = 1'b0;
  endtask

  // Expected write stream for the current RAM image (or an all-zero buffer).
  task automatic push_expect(input bit zero_buf);
    logic [7:0] b [16];
    int r, c, src;
    for (int i = 0; i < 16; i++) b[i] = zero_buf ? 8'h00 : mem[i][7:0];
    for (int a = 0; a < 16; a++) begin
      r   = a % 4;
      c   = a / 4;
      src = r + 4 * ((c - r + 4) % 4);
      exp_q.push_back({5'(a), 24'h000000, inv_ref[b[src]] ^ key_mask});
    end
  endtask

  task automatic do_op(input string tag, input int exp_lat, input bit poke);
    int lat;
    bit seen;
    @(negedge ap_clk); ap_start = 1'b1;
    @(posedge ap_clk); #1; ap_start = 1'b0;
    lat  = 2;
    seen = 1'b0;
    while (lat <= 40 && !seen) begin
      @(negedge ap_clk);
      if (ap_done) seen = 1'b1;
      else begin
        if (poke && lat == 5) ap_start = 1'b1;
        if (poke && lat == 6) ap_start = 1'b0;
        lat++;
      end
    end
    check({tag, "_done_cycle"}, 64'(lat), 64'(exp_lat));
    check({tag, "_ready_with_done"}, {63'd0, ap_ready}, 64'd1);
    @(negedge ap_clk);
    check({tag, "_done_one_cycle"}, {62'd0, ap_done, ap_idle}, 64'b01);
    check({tag, "_all_writes_seen"}, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int          mode;
    logic [23:0] upper;
    bit          poke;
    bit          chk_en;
    int          chk_addr;
    logic [31:0] chk_val;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{mode: 0, upper: 24'h0,      poke: 1'b0, chk_en: 1'b1, chk_addr: 15, chk_val: 32'h00};
    vecs[1] = '{mode: 1, upper: 24'h0,      poke: 1'b0, chk_en: 1'b1, chk_addr: 0,  chk_val: 32'h52};
    vecs[2] = '{mode: 1, upper: 24'h0,      poke: 1'b1, chk_en: 1'b1, chk_addr: 1,  chk_val: 32'hF3};
    vecs[3] = '{mode: 1, upper: 24'h0,      poke: 1'b0, chk_en: 1'b1, chk_addr: 5,  chk_val: 32'h09};
    vecs[4] = '{mode: 1, upper: 24'hABCDEF, poke: 1'b0, chk_en: 1'b1, chk_addr: 1,  chk_val: 32'hF3};
    vecs[5] = '{mode: 2, upper: 24'h0,      poke: 1'b0, chk_en: 1'b0, chk_addr: 0,  chk_val: 32'h00};

    build_inv_ref();
`ifdef LOGIC_LOCK_EN
    key_mask = working_key[20:13] ^ 8'h5A;
`endif

    // Reset state.
    repeat (3) @(negedge ap_clk);
    check("rst_idle_done_ready", {61'd0, ap_idle, ap_done, ap_ready}, 64'b100);
    check("rst_ce_we", {60'd0, statemt_ce0, statemt_we0, statemt_ce1, statemt_we1}, 64'd0);
    check("rst_addr_d", {statemt_address0, statemt_address1, statemt_d0[7:0], statemt_d1[7:0]}, 64'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("post_rst_idle", {63'd0, ap_idle}, 64'd1);

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      load_image(vecs[v].mode, vecs[v].upper);
      push_expect(1'b0);
      rd_cnt = 0;
      do_op($sformatf("vec%0d", v), 19, vecs[v].poke);
      check($sformatf("vec%0d_reads", v), 64'(rd_cnt), 64'd16);
      if (vecs[v].chk_en)
        check($sformatf("vec%0d_word%0d", v, vecs[v].chk_addr), 64'(mem[vecs[v].chk_addr]), 64'(vecs[v].chk_val));
    end

    // Reset during WRITE step 3, then restart.
    load_image(1, 24'h0);
    push_expect(1'b0);
    @(negedge ap_clk); ap_start = 1'b1;
    @(posedge ap_clk); #1; ap_start = 1'b0;
    repeat (13) @(negedge ap_clk);
    check("we_before_reset", {62'd0, statemt_we0, statemt_we1}, 64'b11);
    ap_rst_n = 1'b0;
    #1;
    check("we_drop_on_reset", {62'd0, statemt_we0, statemt_we1}, 64'd0);
    check("idle_on_reset", {61'd0, ap_idle, statemt_ce0, statemt_ce1}, 64'b100);
    #2;
    exp_q.delete();
    @(negedge ap_clk); ap_rst_n = 1'b1;
    check("partial_words_written", {mem[0], mem[5]}, {32'h52, 32'h09});
    check("partial_words_kept", {mem[6], mem[7]}, {32'h06, 32'h07});
    push_expect(1'b0);
    do_op("restart", 19, 1'b0);

`ifdef LOGIC_LOCK_EN
    // Wrong key: skip reads, write the reset buffer with a corrupted mask.
    ap_rst_n = 1'b0;
    @(negedge ap_clk); ap_rst_n = 1'b1;
    working_key = 64'h0123_4567_000B_5000 ^ {43'd0, 8'h0F, 13'd0};
    key_mask    = working_key[20:13] ^ 8'h5A;
    push_expect(1'b1);
    rd_cnt = 0;
    do_op("lock_bad", 10, 1'b0);
    check("lock_bad_reads", 64'(rd_cnt), 64'd0);
    working_key = 64'h0123_4567_000B_4000;
    key_mask    = working_key[20:13] ^ 8'h5A;
    load_image(2, 24'h0);
    push_expect(1'b0);
    do_op("lock_good", 19, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
